// File: rtl/video_mode_detect.sv
// Video timing measurement: per-line and per-frame pixel/line counts, lock after
// STABLE_FRAMES matching frames, interlace detection and a no-VSync watchdog.
module video_mode_detect #(
  parameter int CNT_W         = 12,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT_W     = 24
) (
  input  logic             CLK_VIDEO,
  input  logic             reset_n,
  input  logic             CE_PIXEL,
  input  logic             VGA_HS,
  input  logic             VGA_VS,
  input  logic             VGA_DE,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             interlaced,
  output logic             mode_valid,
  output logic             mode_change
);

  localparam int MCW = $clog2(STABLE_FRAMES + 1) + 1;
  localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_ONE   = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [MCW-1:0]       MC_ONE   = {{(MCW-1){1'b0}}, 1'b1};
  localparam logic [MCW-1:0]       MC_LOCK  = MCW'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_PRIME    = 2'd1,
    ST_CHECK    = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic             hs_hold_r, vs_hold_r;
  logic             hs_rise_s, vs_rise_s, timeout_s;
  logic [CNT_W-1:0] hcnt_r, decnt_r, vcnt_r, vact_r, line_tot_r, frame_hact_r;
  logic [TIMEOUT_W-1:0] wd_r;
  logic [CNT_W-1:0] cand_htot_s, cand_hact_s, cand_vtot_s, cand_vact_s;
  logic [CNT_W-1:0] p_htot_r, p_hact_r, p_vtot_r, p_vact_r;
  logic [CNT_W-1:0] vdiff_s, vmin_s;
  logic             match_s, chg_lock_s, chg_prime_s;
  state_t           state_r;
  logic [MCW-1:0]   match_cnt_r, mc_inc_s;

  // Edge detection, candidate (post-HS-rise) values and the match rule
  always_comb begin
    hs_rise_s = CE_PIXEL & VGA_HS & ~hs_hold_r;
    vs_rise_s = CE_PIXEL & VGA_VS & ~vs_hold_r;
    timeout_s = (&wd_r) & ~vs_rise_s;
    if (hs_rise_s) begin
      cand_htot_s = hcnt_r;
      cand_vtot_s = sat_inc(vcnt_r);
      if (decnt_r != CNT_ZERO) begin
        cand_hact_s = decnt_r;
        cand_vact_s = sat_inc(vact_r);
      end else begin
        cand_hact_s = frame_hact_r;
        cand_vact_s = vact_r;
      end
    end else begin
      cand_htot_s = line_tot_r;
      cand_vtot_s = vcnt_r;
      cand_hact_s = frame_hact_r;
      cand_vact_s = vact_r;
    end
    if (cand_vtot_s >= p_vtot_r) begin
      vdiff_s = cand_vtot_s - p_vtot_r;
      vmin_s  = p_vtot_r;
    end else begin
      vdiff_s = p_vtot_r - cand_vtot_s;
      vmin_s  = cand_vtot_s;
    end
    match_s = (cand_htot_s == p_htot_r) && (cand_hact_s == p_hact_r) &&
              (cand_vact_s == p_vact_r) && (vdiff_s <= CNT_ONE);
    chg_lock_s  = {cand_htot_s, cand_hact_s, vmin_s, cand_vact_s} !=
                  {h_total, h_active, v_total, v_active};
    chg_prime_s = {cand_htot_s, cand_hact_s, cand_vtot_s, cand_vact_s} !=
                  {h_total, h_active, v_total, v_active};
    mc_inc_s = match_cnt_r + MC_ONE;
  end

  // Sync levels as seen on the last pixel-enable cycle
  always_ff @(posedge CLK_VIDEO or negedge reset_n) begin
    if (!reset_n) begin
      hs_hold_r <= 1'b0;
      vs_hold_r <= 1'b0;
    end else if (CE_PIXEL) begin
      hs_hold_r <= VGA_HS;
      vs_hold_r <= VGA_VS;
    end else begin
      hs_hold_r <= hs_hold_r;
      vs_hold_r <= vs_hold_r;
    end
  end

  // Line/frame counters and the no-VSync watchdog
  always_ff @(posedge CLK_VIDEO or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_r       <= CNT_ZERO;
      decnt_r      <= CNT_ZERO;
      vcnt_r       <= CNT_ZERO;
      vact_r       <= CNT_ZERO;
      line_tot_r   <= CNT_ZERO;
      frame_hact_r <= CNT_ZERO;
      wd_r         <= {TIMEOUT_W{1'b0}};
    end else if (timeout_s) begin
      hcnt_r       <= CNT_ZERO;
      decnt_r      <= CNT_ZERO;
      vcnt_r       <= CNT_ZERO;
      vact_r       <= CNT_ZERO;
      line_tot_r   <= CNT_ZERO;
      frame_hact_r <= CNT_ZERO;
      wd_r         <= {TIMEOUT_W{1'b0}};
    end else begin
      wd_r <= vs_rise_s ? {TIMEOUT_W{1'b0}} : wd_r + WD_ONE;
      if (CE_PIXEL) begin
        line_tot_r <= cand_htot_s;
        if (hs_rise_s) begin
          hcnt_r  <= CNT_ONE;
          decnt_r <= VGA_DE ? CNT_ONE : CNT_ZERO;
        end else begin
          hcnt_r  <= sat_inc(hcnt_r);
          decnt_r <= VGA_DE ? sat_inc(decnt_r) : decnt_r;
        end
        // The coincident HS rise is already folded into the candidate before clearing
        if (vs_rise_s) begin
          vcnt_r       <= CNT_ZERO;
          vact_r       <= CNT_ZERO;
          frame_hact_r <= CNT_ZERO;
        end else begin
          vcnt_r       <= cand_vtot_s;
          vact_r       <= cand_vact_s;
          frame_hact_r <= cand_hact_s;
        end
      end
    end
  end

  // Lock FSM with registered published outputs
  always_ff @(posedge CLK_VIDEO or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_UNLOCKED;
      match_cnt_r <= {MCW{1'b0}};
      p_htot_r    <= CNT_ZERO;
      p_hact_r    <= CNT_ZERO;
      p_vtot_r    <= CNT_ZERO;
      p_vact_r    <= CNT_ZERO;
      h_total     <= CNT_ZERO;
      h_active    <= CNT_ZERO;
      v_total     <= CNT_ZERO;
      v_active    <= CNT_ZERO;
      interlaced  <= 1'b0;
      mode_valid  <= 1'b0;
      mode_change <= 1'b0;
    end else begin
      mode_change <= 1'b0;
      if (timeout_s) begin
        state_r     <= ST_UNLOCKED;
        match_cnt_r <= {MCW{1'b0}};
        mode_valid  <= 1'b0;
      end else if (vs_rise_s) begin
        if (state_r != ST_UNLOCKED) begin
          p_htot_r <= cand_htot_s;
          p_hact_r <= cand_hact_s;
          p_vtot_r <= cand_vtot_s;
          p_vact_r <= cand_vact_s;
        end
        case (state_r)
          // First candidate after reset/timeout covers a partial frame
          ST_UNLOCKED: state_r <= ST_PRIME;
          ST_PRIME: begin
            match_cnt_r <= MC_ONE;
            if (STABLE_FRAMES <= 1) begin
              h_total     <= cand_htot_s;
              h_active    <= cand_hact_s;
              v_total     <= cand_vtot_s;
              v_active    <= cand_vact_s;
              interlaced  <= 1'b0;
              mode_valid  <= 1'b1;
              mode_change <= chg_prime_s;
              state_r     <= ST_LOCKED;
            end else begin
              state_r <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (match_s && (mc_inc_s >= MC_LOCK)) begin
              match_cnt_r <= mc_inc_s;
              h_total     <= cand_htot_s;
              h_active    <= cand_hact_s;
              v_total     <= vmin_s;
              v_active    <= cand_vact_s;
              interlaced  <= (vdiff_s != CNT_ZERO);
              mode_valid  <= 1'b1;
              mode_change <= chg_lock_s;
              state_r     <= ST_LOCKED;
            end else if (match_s) begin
              match_cnt_r <= mc_inc_s;
            end else begin
              match_cnt_r <= MC_ONE;
            end
          end
          ST_LOCKED: begin
            if (match_s) begin
              v_total    <= vmin_s;
              interlaced <= (vdiff_s != CNT_ZERO);
            end else begin
              mode_valid  <= 1'b0;
              match_cnt_r <= MC_ONE;
              state_r     <= ST_CHECK;
            end
          end
          default: state_r <= ST_UNLOCKED;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_video_mode_detect.sv
// Directed-frame bench: expected mode reports are queued as each frame is driven
// and compared on the clock after its VS rise.
module tb_video_mode_detect;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n, ce, hs, vs, de;
  logic [CW-1:0] h_total, h_active, v_total, v_active;
  logic          interlaced, mode_valid, mode_change;

  int vectors = 0, miscompares = 0, exp_pulses = 0, pulse_cnt = 0;
  int cyc = 0, vs_cyc = 0, ce_div = 2;
  string         tag_q[$];
  logic [34:0]   exp_q[$];

  video_mode_detect #(.CNT_W(CW), .STABLE_FRAMES(2), .TIMEOUT_W(10)) dut (
    .CLK_VIDEO(clk), .reset_n(rst_n), .CE_PIXEL(ce), .VGA_HS(hs), .VGA_VS(vs),
    .VGA_DE(de), .h_total(h_total), .h_active(h_active), .v_total(v_total),
    .v_active(v_active), .interlaced(interlaced), .mode_valid(mode_valid),
    .mode_change(mode_change)
  );

  always #5 clk = ~clk;

  // Cycle counter and independent count of mode_change pulses
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mode_change === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  function automatic logic [34:0] pack(input logic v, input logic c, input logic il,
                                       input int ht, input int ha, input int vt, input int va);
    return {v, c, il, 8'(ht), 8'(ha), 8'(vt), 8'(va)};
  endfunction

  task automatic check(input string tag, input logic [34:0] exp);
    logic [34:0] got;
    got = {mode_valid, mode_change, interlaced, h_total, h_active, v_total, v_active};
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got v/c/il=%b%b%b ht=%0d ha=%0d vt=%0d va=%0d, want v/c/il=%b%b%b ht=%0d ha=%0d vt=%0d va=%0d",
             tag, got[34], got[33], got[32], got[31:24], got[23:16], got[15:8], got[7:0],
             exp[34], exp[33], exp[32], exp[31:24], exp[23:16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic push(input string tag, input logic v, input logic c, input logic il,
                      input int ht, input int ha, input int vt, input int va);
    tag_q.push_back(tag);
    exp_q.push_back(pack(v, c, il, ht, ha, vt, va));
    exp_pulses += int'(c);
  endtask

  task automatic clk1();
    @(negedge clk) ce = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic ce_tick(input logic h, input logic v, input logic d);
    for (int i = 0; i < ce_div - 1; i++) clk1();
    @(negedge clk);
    hs = h; vs = v; de = d; ce = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One frame: VS rises on line 0 at CE position vs_pos, DE on lines 2..vact+1
  task automatic frame(input int lines, input int htot, input int hact, input int vact,
                       input int vs_pos);
    logic [34:0] e;
    string t;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < htot; p++) begin
        ce_tick(p < 2, (l == 0 && p >= vs_pos) || (l == 1 && p < vs_pos),
                (l >= 2) && (l < 2 + vact) && (p >= 4) && (p < 4 + hact));
        if (l == 0 && p == vs_pos) begin
          vs_cyc = cyc;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_empty: got VS report, want queued expectation");
          end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, e);
            e[33] = 1'b0;
            clk1();
            check({t, "_next"}, e);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", pack(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;

    // Steady source, coincident HS+VS, then a mid-line VS
    ce_div = 3;
    push("a1_discard", 0, 0, 0, 0, 0, 0, 0);   frame(14, 20, 12, 10, 0);
    push("a2_prime",   0, 0, 0, 0, 0, 0, 0);   frame(14, 20, 12, 10, 0);
    push("a3_lock",    1, 1, 0, 20, 12, 14, 10); frame(14, 20, 12, 10, 0);
    ce_div = 2;
    push("a4_steady",  1, 0, 0, 20, 12, 14, 10); frame(14, 20, 12, 10, 0);
    push("a5_steady",  1, 0, 0, 20, 12, 14, 10); frame(14, 20, 12, 10, 7);
    push("a6_steady",  1, 0, 0, 20, 12, 14, 10); frame(14, 20, 12, 10, 0);

    // Active width change while locked
    push("w1_match",    1, 0, 0, 20, 12, 14, 10); frame(14, 20, 10, 10, 0);
    push("w2_mismatch", 0, 0, 0, 20, 12, 14, 10); frame(14, 20, 10, 10, 0);
    push("w3_relock",   1, 1, 0, 20, 10, 14, 10); frame(14, 20, 10, 10, 0);
    push("w4_steady",   1, 0, 0, 20, 10, 14, 10); frame(14, 20, 10, 10, 0);

    // Alternating 15/14-line fields
    push("x1_match",    1, 0, 0, 20, 10, 14, 10); frame(15, 20, 8, 10, 0);
    push("x2_mismatch", 0, 0, 0, 20, 10, 14, 10); frame(14, 20, 8, 10, 0);
    push("x3_lock_il",  1, 1, 1, 20, 8, 14, 10);  frame(15, 20, 8, 10, 0);
    for (int k = 4; k <= 10; k++) begin
      push("x_hold_il", 1, 0, 1, 20, 8, 14, 10);
      frame((k % 2 == 1) ? 15 : 14, 20, 8, 10, 0);
    end

    // VS stops: watchdog expires 1024 clocks after the last VS rise
    while (cyc < vs_cyc + 1023) clk1();
    check("wd_before", pack(1, 0, 1, 20, 8, 14, 10));
    clk1();
    check("wd_expired", pack(0, 0, 1, 20, 8, 14, 10));

    push("r1_discard", 0, 0, 1, 20, 8, 14, 10);  frame(14, 20, 12, 10, 0);
    push("r2_prime",   0, 0, 1, 20, 8, 14, 10);  frame(14, 20, 12, 10, 0);
    push("r3_relock",  1, 1, 0, 20, 12, 14, 10); frame(14, 20, 12, 10, 0);
    push("r4_steady",  1, 0, 0, 20, 12, 14, 10); frame(14, 20, 12, 10, 0);

    // Asynchronous reset away from any clock edge
    #2 rst_n = 1'b0;
    #1 check("async_reset", pack(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push("s1_discard", 0, 0, 0, 0, 0, 0, 0);   frame(14, 20, 12, 10, 0);
    push("s2_prime",   0, 0, 0, 0, 0, 0, 0);   frame(14, 20, 12, 10, 0);
    push("s3_lock",    1, 1, 0, 20, 12, 14, 10); frame(14, 20, 12, 10, 0);
    push("s4_steady",  1, 0, 0, 20, 12, 14, 10); frame(14, 20, 12, 10, 0);

    vectors++;
    assert (pulse_cnt === exp_pulses) else begin
      miscompares++;
      $error("FAIL pulse_count: got %0d mode_change pulses, want %0d", pulse_cnt, exp_pulses);
    end
    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_leftover: got %0d unchecked expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/video_mode_detect.md
# video_mode_detect

Measures the video timing leaving the video mixer: total and active pixels per line, and total and active lines per frame. It declares a mode valid after a configurable number of identical consecutive frames, and flags interlaced (alternating-field) sources. It sits directly downstream of the mixer and consumes its VGA_* outputs and CE_PIXEL. It feeds OSD and status reporting, and gates any scaler/HDMI reconfiguration on a mode change.

## Interface
- CNT_W, 12: width of all pixel/line counters and measured outputs.
- STABLE_FRAMES, 2: number of consecutive matching complete frames required to lock (≥1).
- TIMEOUT_W, 24: width of the no-VSync watchdog; timeout after 2^TIMEOUT_W CLK_VIDEO cycles.

- CLK_VIDEO  in  1  video clock; one clock domain for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- CE_PIXEL  in  1  pixel clock enable; sync/DE are sampled only when high.
- VGA_HS  in  1  horizontal sync, positive pulse.
- VGA_VS  in  1  vertical sync, positive pulse.
- VGA_DE  in  1  data enable.
- h_total  out  CNT_W  CE cycles between HS rising edges.
- h_active  out  CNT_W  DE-high CE cycles in the last active line of the frame.
- v_total  out  CNT_W  lines per frame; the smaller field when interlaced.
- v_active  out  CNT_W  lines with nonzero DE per frame.
- interlaced  out  1  locked mode alternates v_total by exactly 1.
- mode_valid  out  1  outputs describe a stable mode.
- mode_change  out  1  one-CLK pulse when a new lock publishes values differing from the previous published set.

## Operation
- Edge detect: registers hold HS/VS as sampled on the last CE_PIXEL cycle. A rise is a CE cycle with the input high and the held value low. Non-CE cycles change no counter.
- hcnt: set to 1 on an HS-rise CE cycle; otherwise +1 per CE cycle, saturating at all-ones. On an HS rise, the old hcnt latches into line_tot.
- decnt: counts DE-high CE cycles in the current line, saturating. On an HS rise, a nonzero decnt latches into frame_hact. decnt then clears, or becomes 1 if DE is high on that cycle.
- vcnt counts HS rises since the last VS rise. vact counts HS rises whose closing line had decnt ≠ 0. Both saturate.
- HS and VS rising in the same CE cycle: the HS rise is processed first and is included in the latched vcnt/vact. vcnt, vact and frame_hact then clear.
- VS rise forms a candidate C = {line_tot, frame_hact, vcnt, vact}.
  - The candidate at the first VS rise after reset or timeout is partial and is discarded.
- Match rule: C matches the previous candidate P when h_tot, h_act and v_act are equal and |v_tot_C − v_tot_P| ≤ 1.
- FSM states:
  - UNLOCKED: skip the first candidate, store it as P, go to CHECK with match_cnt=1.
  - CHECK:
    - On a match, match_cnt+1. When match_cnt reaches STABLE_FRAMES, publish and go to LOCKED.
    - On a mismatch, match_cnt=1.
    - P ← C on every candidate.
  - LOCKED:
    - On a match, stay, republish v_total min/interlaced, no pulse.
    - On a mismatch, mode_valid←0, match_cnt=1, go to CHECK.
- Publish:
  - v_total = min(v_tot_C, v_tot_P).
  - interlaced = (v_tot_C ≠ v_tot_P).
  - mode_valid = 1.
  - mode_change = 1 if {h_total, h_active, v_total, v_active} differs from the previous published set, which is all zeros after reset.
- Watchdog: counts CLK_VIDEO cycles and clears on each VS rise. At terminal count it goes to UNLOCKED with mode_valid←0 and counters cleared. Published values are retained until the next publish.

## Timing
- Reset (asynchronous, immediate): all outputs 0, FSM UNLOCKED, all counters 0, held HS/VS = 0.
- Published outputs, mode_valid and mode_change update on the CLK_VIDEO edge following the VS-rise CE cycle: 1-cycle latency.
- mode_change is high for exactly one CLK_VIDEO cycle.
- mode_valid falls in the same cycle a mismatch is evaluated, or on the cycle after the watchdog terminal count.
- Lock occurs at the (STABLE_FRAMES+1)-th VS rise after reset for a steady source.
- Counter saturation: saturated values are used as-is. A saturated source can still lock.

## Test plan
- Reset: assert reset_n=0 mid-stream -> all outputs 0 within the same cycle; FSM restarts and relocks at the 3rd VS rise after release.
- Steady mode, CE every 4 clocks, h_total 341, DE 256/line, 262 lines of which 240 active, STABLE_FRAMES=2 -> at the 3rd VS rise: mode_valid=1, values 341/256/262/240, interlaced=0, one mode_change pulse; no further pulses over 10 frames.
- Width change 256→240 while locked -> mode_valid=0 at the next VS rise; relock two frames later with h_active=240 and a single mode_change pulse.
- Alternating 262/263-line fields -> lock with v_total=262, interlaced=1; stays locked over 8 frames with no mode_change repeats.
- Coincident HS+VS rise on the same CE cycle -> v_total includes that line (262, not 261).
- Hold VS low, TIMEOUT_W=10 -> mode_valid=0 after 1024 clocks from the last VS rise; h_total etc. retained; relock after VS resumes.
